// File: rtl/bp_sched.sv
// gshare PHT scheduler: owns the GHR, runs PHT init, arbitrates one PHT port between lookups and resolves.
// Optional statistics counters are built when BP_SCHED_STATS_EN is defined.
module bp_sched #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              rs_valid,
    input  logic              rs_taken,
    output logic              rs_ready,
    output logic              rs_mispredict,
    output logic              pht_en,
    output logic              pht_we,
    output logic [IDX_W-1:0]  pht_idx,
    output logic [1:0]        pht_wdata,
    input  logic [1:0]        pht_rdata,
    output logic              init_busy
`ifdef BP_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_total,
    output logic [CNT_W-1:0]  stat_mispred
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  init_ptr;
    logic [IDX_W-1:0]  ghr;
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  q_idx [DEPTH];
    logic [1:0]        q_ctr [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [OCC_W-1:0]  occ;
    logic              rd_vld_p1;
    logic [IDX_W-1:0]  rd_idx_p1;
    logic              rs_acc, lk_acc, run;
    logic              addr_unused;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign addr_unused = ^lk_addr[ADDR_W-1:IDX_W];
    assign lk_idx      = ghr ^ lk_addr[IDX_W-1:0];
    assign run         = (state == S_RUN);
    assign rs_ready    = run && (occ != '0);
    assign rs_acc      = rs_valid && rs_ready;
    // Occupancy counts the read in flight so its push always finds a free slot.
    assign lk_ready    = run && !rs_acc && ((occ + OCC_W'(rd_vld_p1)) < OCC_W'(DEPTH));
    assign lk_acc      = lk_valid && lk_ready;

    assign pred_valid    = rd_vld_p1;
    assign pred_taken    = rd_vld_p1 && pht_rdata[1];
    assign rs_mispredict = rs_acc && (q_ctr[head][1] != rs_taken);

    always_comb begin
        state_nxt = state;
        pht_en    = 1'b0;
        pht_we    = 1'b0;
        pht_idx   = '0;
        pht_wdata = 2'b00;
        init_busy = 1'b0;
        case (state)
            S_INIT: begin
                init_busy = 1'b1;
                pht_en    = 1'b1;
                pht_we    = 1'b1;
                pht_idx   = init_ptr;
                pht_wdata = 2'b01;
                if (&init_ptr)
                    state_nxt = S_RUN;
            end
            default: begin
                if (rs_acc) begin
                    pht_en    = 1'b1;
                    pht_we    = 1'b1;
                    pht_idx   = q_idx[head];
                    pht_wdata = sat_ctr(q_ctr[head], rs_taken);
                end else if (lk_acc) begin
                    pht_en  = 1'b1;
                    pht_idx = lk_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            init_ptr  <= '0;
            ghr       <= '0;
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_vld_p1 <= lk_acc;
            if (state == S_INIT)
                init_ptr <= init_ptr + IDX_W'(1);
            if (rs_acc) begin
                ghr  <= {ghr[IDX_W-2:0], rs_taken};
                head <= head + PTR_W'(1);
            end
            if (rd_vld_p1)
                tail <= tail + PTR_W'(1);
            case ({rd_vld_p1, rs_acc})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // p0 -> p1: lookup index held while the PHT read completes, then captured into the queue
    always_ff @(posedge clk) begin
        rd_idx_p1 <= lk_idx;
        if (rd_vld_p1) begin
            q_idx[tail] <= rd_idx_p1;
            q_ctr[tail] <= pht_rdata;
        end
    end

`ifdef BP_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total   <= '0;
            stat_mispred <= '0;
        end else begin
            if (rs_acc)
                stat_total <= sat_inc(stat_total);
            if (rs_mispredict)
                stat_mispred <= sat_inc(stat_mispred);
        end
    end
`endif

endmodule

// File: tb/tb_bp_sched.sv
// Bench for bp_sched: behavioural PHT RAM plus a reference model and prediction scoreboard.
module tb_bp_sched;
    localparam int IDX_W  = 4;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              lk_valid = 1'b0;
    logic [ADDR_W-1:0] lk_addr = '0;
    logic              lk_ready;
    logic              pred_valid, pred_taken;
    logic              rs_valid = 1'b0, rs_taken = 1'b0;
    logic              rs_ready, rs_mispredict;
    logic              pht_en, pht_we;
    logic [IDX_W-1:0]  pht_idx;
    logic [1:0]        pht_wdata;
    logic [1:0]        pht_rdata = 2'b00;
    logic              init_busy;
`ifdef BP_SCHED_STATS_EN
    logic [CNT_W-1:0]  stat_total, stat_mispred;
`endif

    bp_sched #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .rs_valid(rs_valid), .rs_taken(rs_taken), .rs_ready(rs_ready),
        .rs_mispredict(rs_mispredict),
        .pht_en(pht_en), .pht_we(pht_we), .pht_idx(pht_idx),
        .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
        .init_busy(init_busy)
`ifdef BP_SCHED_STATS_EN
        , .stat_total(stat_total), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    // PHT RAM, preloaded with strong-taken so that a missing init shows up
    logic [1:0] ram [16];
    initial for (int k = 0; k < 16; k++) ram[k] = 2'b11;
    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we) ram[pht_idx] <= pht_wdata;
            else        pht_rdata    <= ram[pht_idx];
        end
    end

    typedef struct { logic [3:0] idx; logic [1:0] ctr; } ent_t;
    ent_t       ref_q [$];
    bit         exp_pred [$];
    logic [1:0] ref_pht [16];
    logic [3:0] ref_ghr;
    bit         pend;
    int         n_cmp = 0, n_err = 0, n_res = 0, n_misp = 0;
    logic       last_lkr, last_misp;
    logic [3:0] last_idx;
    logic [1:0] last_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_sat(input logic [1:0] c, input bit t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) ref_pht[k] = 2'b01;
        ref_ghr = '0;
        ref_q.delete();
        exp_pred.delete();
        pend   = 0;
        n_res  = 0;
        n_misp = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model.
    task automatic step(input bit lv, input logic [ADDR_W-1:0] addr, input bit rv, input bit rt);
        int   occ;
        bit   e_rsr, e_lkr, nxt_pend;
        ent_t e;
        logic [3:0] li;
        lk_valid = lv; lk_addr = addr; rs_valid = rv; rs_taken = rt;
        @(negedge clk);
        occ   = ref_q.size() - int'(pend);
        e_rsr = occ > 0;
        e_lkr = !(rv && e_rsr) && (ref_q.size() < DEPTH);
        chk("init_busy", init_busy, 0);
        chk("rs_ready", rs_ready, e_rsr);
        chk("lk_ready", lk_ready, e_lkr);
        chk("pred_valid", pred_valid, pend);
        if (pred_valid) begin
            chk("pred_sb_nonempty", exp_pred.size() != 0, 1);
            if (exp_pred.size() != 0) chk("pred_taken", pred_taken, exp_pred.pop_front());
        end
        last_lkr = lk_ready; last_idx = pht_idx; last_wdata = pht_wdata; last_misp = rs_mispredict;
        if (rv && e_rsr) begin
            e = ref_q.pop_front();
            chk("rs_en_we", {pht_en, pht_we}, 2'b11);
            chk("rs_idx", pht_idx, e.idx);
            chk("rs_wdata", pht_wdata, ref_sat(e.ctr, rt));
            chk("rs_misp", rs_mispredict, e.ctr[1] != rt);
            ref_pht[e.idx] = ref_sat(e.ctr, rt);
            ref_ghr = {ref_ghr[2:0], rt};
            n_res++;
            if (e.ctr[1] != rt) n_misp++;
        end else begin
            chk("rs_misp_idle", rs_mispredict, 0);
        end
        if (lv && e_lkr) begin
            li = ref_ghr ^ addr[3:0];
            chk("lk_en_we", {pht_en, pht_we}, 2'b10);
            chk("lk_idx", pht_idx, li);
            ref_q.push_back('{idx: li, ctr: ref_pht[li]});
            exp_pred.push_back(ref_pht[li][1]);
        end else if (!(rv && e_rsr)) begin
            chk("pht_idle", pht_en, 0);
        end
        nxt_pend = lv && e_lkr;
        @(posedge clk); #1;
        pend = nxt_pend;
    endtask

    task automatic init_check();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_busy_hi", init_busy, 1);
            chk("init_en_we", {pht_en, pht_we}, 2'b11);
            chk("init_idx", pht_idx, 32'(i));
            chk("init_wdata", pht_wdata, 2'b01);
            chk("init_lkr", lk_ready, 0);
            chk("init_rsr", rs_ready, 0);
            chk("init_pv", pred_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && ref_q.size() > 0; g++)
            step(0, '0, 1, 1'($urandom_range(0, 1)));
        chk("drain_empty", ref_q.size(), 0);
    endtask

    task automatic lk_rs(input logic [3:0] target, input bit t);
        step(1, ADDR_W'(target ^ ref_ghr), 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, t);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_lkr", lk_ready, 0);
        chk("rst_rsr", rs_ready, 0);
        chk("rst_pv", pred_valid, 0);
        chk("rst_pt", pred_taken, 0);
        chk("rst_misp", rs_mispredict, 0);
        chk("rst_busy", init_busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        init_check();

        // lookup at 0x005, resolve taken, then the same address hashes with GHR=0001
        step(1, 11'h005, 0, 0);
        chk("plan_idx5", last_idx, 5);
        step(0, '0, 0, 0);
        step(0, '0, 1, 1);
        chk("plan_wdata10", last_wdata, 2'b10);
        chk("plan_misp", last_misp, 1);
        step(1, 11'h005, 0, 0);
        chk("plan_idx4", last_idx, 4);
        drain();

        // fill the queue, then resolve alongside a competing lookup
        for (int i = 0; i < 4; i++) step(1, ADDR_W'($urandom), 0, 0);
        step(1, ADDR_W'($urandom), 0, 0);
        chk("full_lkr", last_lkr, 0);
        step(1, ADDR_W'($urandom), 1, 1);
        chk("prio_lkr", last_lkr, 0);
        step(1, ADDR_W'($urandom), 0, 0);
        chk("resume_lkr", last_lkr, 1);
        drain();

        // saturation at both ends
        for (int i = 0; i < 3; i++) lk_rs(4'd7, 1);
        chk("sat_hi", last_wdata, 2'b11);
        for (int i = 0; i < 2; i++) lk_rs(4'd9, 0);
        chk("sat_lo", last_wdata, 2'b00);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), ADDR_W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        drain();
`ifdef BP_SCHED_STATS_EN
        chk("stat_total", stat_total, n_res);
        chk("stat_mispred", stat_mispred, n_misp);
`endif

        // reset with three entries queued and a fourth read in flight
        for (int i = 0; i < 3; i++) step(1, ADDR_W'($urandom), 0, 0);
        reset = 1'b1;
        step(1, ADDR_W'($urandom), 0, 0);
        model_reset();
        @(negedge clk);
        chk("rr_pv", pred_valid, 0);
        chk("rr_rsr", rs_ready, 0);
        chk("rr_busy", init_busy, 1);
`ifdef BP_SCHED_STATS_EN
        chk("rr_stat_total", stat_total, 0);
        chk("rr_stat_mispred", stat_mispred, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        init_check();
        step(1, 11'h005, 0, 0);
        chk("rr_ghr_idx5", last_idx, 5);
        step(0, '0, 0, 0);
        drain();
        chk("sb_drained", exp_pred.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bp_sched.md
# bp_sched

Scheduler and port arbiter for the gshare branch predictor's pattern history table (PHT). It owns the global history register (GHR) and sequences PHT initialisation after reset. It serves prediction lookups from fetch and in-order resolutions from execute through one single-port PHT, queueing in-flight predictions until they resolve. It sits between the fetch/execute interfaces and an external synchronous PHT RAM.

## Interface
- IDX_W, 4, PHT index width and GHR width; the PHT has 2^IDX_W entries.
- ADDR_W, 11, branch address width; ADDR_W ≥ IDX_W.
- DEPTH, 4, in-flight prediction queue depth; power of two, ≥ 2.
- CNT_W, 16, statistics counter width.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- lk_valid  in  1  lookup request.
- lk_addr  in  ADDR_W  branch address.
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready.
- pred_valid  out  1  prediction pulse, one cycle.
- pred_taken  out  1  predicted direction.
- rs_valid  in  1  resolution of the oldest outstanding prediction.
- rs_taken  in  1  actual outcome.
- rs_ready  out  1  resolution accepted when rs_valid && rs_ready.
- rs_mispredict  out  1  pulse in the accept cycle if the stored prediction differs from rs_taken.
- pht_en, pht_we  out  1  PHT port enable and write enable.
- pht_idx  out  IDX_W  PHT address.
- pht_wdata  out  2  write data.
- pht_rdata  in  2  read data, valid the cycle after a read.
- init_busy  out  1  high while initialisation is in progress.
- stat_total, stat_mispred  out  CNT_W  statistics counters; present only with BP_SCHED_STATS_EN.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is bit 1.
- State machine INIT → RUN.
  - Reset enters INIT with the init pointer at 0.
  - Each INIT cycle writes: pht_en=1, pht_we=1, pht_idx=pointer, pht_wdata=01. The pointer then increments.
  - After writing index 2^IDX_W−1, the block moves to RUN.
  - In INIT, lk_ready=0, rs_ready=0 and init_busy=1.
- PHT port outputs are combinational in the access cycle. The PHT samples them at the next posedge.
- Resolve path (RUN):
  - rs_ready = queue not empty.
  - On accept, pop the head entry {idx, ctr, pred}.
  - Write the saturating update to idx: increment toward 11 if taken, decrement toward 00 if not.
  - GHR ← {GHR[IDX_W−2:0], rs_taken}.
  - rs_mispredict = pred != rs_taken.
- Lookup path (RUN):
  - lk_ready = !(rs_valid && rs_ready) && (occupancy + inflight < DEPTH). inflight is 1 if a lookup was accepted last cycle.
  - On accept, read index GHR ^ lk_addr[IDX_W−1:0].
  - In the next cycle, pred_valid=1 and pred_taken=pht_rdata[1]. In the same cycle, {idx, pht_rdata, pht_rdata[1]} is pushed to the queue tail.
- Resolution has strict priority over lookup for the port.
- The GHR is non-speculative: it changes only on resolve.
- Updates use the counter captured at lookup. A write to the same index between lookup and resolve is overwritten; this staleness is accepted behaviour.

## Timing
- Reset values:
  - lk_ready=0, rs_ready=0, pred_valid=0, pred_taken=0, rs_mispredict=0, init_busy=1.
  - GHR=0, queue empty, statistics 0.
  - pht_* outputs carry INIT writes from the first cycle after reset deasserts.
- Initialisation takes 2^IDX_W cycles. lk_ready can first rise in cycle 2^IDX_W after reset deasserts (16 for IDX_W=4).
- Lookup latency: accept at T, pred_valid at T+1. The earliest matching resolve accept is T+2, because the entry is pushed at T+1.
- Throughput: one lookup per cycle when no resolve is accepted.
- Full queue: lk_ready=0. An accepted resolve frees a slot; lookup resumes the cycle after.
- Empty queue: rs_ready=0. rs_valid with no outstanding prediction is held off, never dropped.
- Reset asserted mid-operation:
  - Queue and the in-flight read are flushed; no pred_valid is emitted for a pending read.
  - GHR and counters clear, and INIT restarts.
- Queue pointers wrap modulo DEPTH.

## Configuration
- BP_SCHED_STATS_EN defined:
  - stat_total increments on each accepted resolve.
  - stat_mispred increments on each mispredicted resolve.
  - Both saturate at 2^CNT_W−1 and clear on reset.
- BP_SCHED_STATS_EN undefined: the counters and both stat ports are absent. All other behaviour is identical.

## Test plan
- Reset release with IDX_W=4 → 16 consecutive writes, idx 0..15, wdata 01, init_busy high throughout; lk_ready=1 at cycle 16.
- After init, lookup lk_addr=0x005 → read idx 5, pred_valid with pred_taken=0 next cycle. Resolve rs_taken=1 → write idx 5 wdata 10, rs_mispredict=1, GHR=0001. A new lookup at 0x005 reads idx 4.
- Four back-to-back lookups with no resolves (DEPTH=4) → four pred_valid pulses, lk_ready=0 after the 4th accept. One resolve → lk_ready=1 the following cycle.
- rs_valid and lk_valid both high with a non-empty queue → pht_we=1 for the resolve, lk_ready=0, the lookup is accepted the next cycle.
- Saturation: counter at 11 resolved taken → wdata 11; counter at 00 resolved not-taken → wdata 00. With BP_SCHED_STATS_EN, stat_total and stat_mispred match the mispredict pulses counted by the bench.
- Reset with 3 queued entries and a read in flight → no pred_valid afterwards, rs_ready=0, GHR=0, full 16-cycle INIT re-run.
